// File: rtl/gt_pcs_pkg.sv
// Shared 64B/66B PCS definitions: block-sync FSM states, sync header codes and default thresholds.
// Purely declarative; no latency or flow-control behaviour of its own.
package gt_pcs_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST_SH,
    SLIP,
    SLIP_WAIT
  } sync_state_e;

  localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
  localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

  localparam int SH_CNT_MAX_DEF     = 64;
  localparam int SH_INVALID_MAX_DEF = 16;
  localparam int SLIP_WAIT_DEF      = 32;

  function automatic logic sync_hdr_ok(input logic [1:0] hdr);
    return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
  endfunction

endpackage

// File: rtl/gt_rx_block_sync.sv
// 64B/66B RX block sync: slips the gearbox until sync headers align, then forwards lock-qualified blocks.
// 1-cycle data latency, no backpressure; define GT_RX_BLOCK_SYNC_STATS_EN for slip/lock-loss counters.
module gt_rx_block_sync #(
  parameter int SH_CNT_MAX     = gt_pcs_pkg::SH_CNT_MAX_DEF,
  parameter int SH_INVALID_MAX = gt_pcs_pkg::SH_INVALID_MAX_DEF,
  parameter int SLIP_WAIT      = gt_pcs_pkg::SLIP_WAIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_rx_data,
  input  logic        i_rx_valid,
  input  logic [1:0]  i_rx_header,
  input  logic        i_rx_header_valid,
  output logic        o_rx_slipbit,
  output logic        o_block_lock,
  output logic [63:0] o_rx_data,
  output logic [1:0]  o_rx_header,
  output logic        o_rx_valid
`ifdef GT_RX_BLOCK_SYNC_STATS_EN
  ,
  output logic [15:0] o_slip_cnt,
  output logic [15:0] o_lock_loss_cnt
`endif
);
  import gt_pcs_pkg::*;

  localparam int CNT_W  = $clog2(SH_CNT_MAX + 1);
  localparam int INV_W  = $clog2(SH_INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  // The SLIP_WAIT parameter shadows the package state of the same name, hence the qualified references.
  sync_state_e        state_q, state_d;
  logic [CNT_W-1:0]   sh_cnt_q, sh_cnt_d, sh_cnt_inc;
  logic [INV_W-1:0]   sh_invalid_cnt_q, sh_invalid_cnt_d, sh_invalid_inc;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               lock_q, lock_d;
  logic [63:0]        rx_data_q, rx_data_d;
  logic [1:0]         rx_header_q, rx_header_d;
  logic               rx_valid_q, rx_valid_d;
  logic               hdr_ok;

  assign hdr_ok         = sync_hdr_ok(i_rx_header);
  assign sh_cnt_inc     = sh_cnt_q + CNT_W'(1);
  assign sh_invalid_inc = sh_invalid_cnt_q + {{(INV_W-1){1'b0}}, ~hdr_ok};

  always_comb begin
    state_d          = state_q;
    sh_cnt_d         = sh_cnt_q;
    sh_invalid_cnt_d = sh_invalid_cnt_q;
    wait_cnt_d       = wait_cnt_q;
    lock_d           = lock_q;
    rx_data_d        = i_rx_data;
    rx_header_d      = i_rx_header;
    rx_valid_d       = i_rx_valid & lock_q;

    unique case (state_q)
      LOCK_INIT: begin
        sh_cnt_d         = '0;
        sh_invalid_cnt_d = '0;
        lock_d           = 1'b0;
        state_d          = TEST_SH;
      end
      TEST_SH: begin
        if (i_rx_header_valid) begin
          sh_cnt_d         = sh_cnt_inc;
          sh_invalid_cnt_d = sh_invalid_inc;
          if (!lock_q) begin
            if (!hdr_ok) begin
              state_d = SLIP;
            end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
              lock_d           = 1'b1;
              sh_cnt_d         = '0;
              sh_invalid_cnt_d = '0;
            end
          // Loss of lock is checked first so it wins over a coincident window end.
          end else if (sh_invalid_inc == INV_W'(SH_INVALID_MAX)) begin
            lock_d  = 1'b0;
            state_d = SLIP;
          end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
            sh_cnt_d         = '0;
            sh_invalid_cnt_d = '0;
          end
        end
      end
      SLIP: begin
        lock_d     = 1'b0;
        wait_cnt_d = '0;
        state_d    = gt_pcs_pkg::SLIP_WAIT;
      end
      gt_pcs_pkg::SLIP_WAIT: begin
        lock_d = 1'b0;
        if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
          sh_cnt_d         = '0;
          sh_invalid_cnt_d = '0;
          state_d          = TEST_SH;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = LOCK_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= LOCK_INIT;
      sh_cnt_q         <= '0;
      sh_invalid_cnt_q <= '0;
      wait_cnt_q       <= '0;
      lock_q           <= 1'b0;
      rx_data_q        <= '0;
      rx_header_q      <= '0;
      rx_valid_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      sh_cnt_q         <= sh_cnt_d;
      sh_invalid_cnt_q <= sh_invalid_cnt_d;
      wait_cnt_q       <= wait_cnt_d;
      lock_q           <= lock_d;
      rx_data_q        <= rx_data_d;
      rx_header_q      <= rx_header_d;
      rx_valid_q       <= rx_valid_d;
    end
  end

  assign o_rx_slipbit = (state_q == SLIP);
  assign o_block_lock = lock_q;
  assign o_rx_data    = rx_data_q;
  assign o_rx_header  = rx_header_q;
  assign o_rx_valid   = rx_valid_q;

`ifdef GT_RX_BLOCK_SYNC_STATS_EN
  logic [15:0] slip_cnt_q, slip_cnt_d;
  logic [15:0] lock_loss_cnt_q, lock_loss_cnt_d;

  always_comb begin
    slip_cnt_d      = slip_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;
    if ((state_q == SLIP) && (slip_cnt_q != 16'hFFFF)) begin
      slip_cnt_d = slip_cnt_q + 16'd1;
    end
    // Only FSM-driven drops count; reset clears the counter along with the lock.
    if (lock_q && !lock_d && (lock_loss_cnt_q != 16'hFFFF)) begin
      lock_loss_cnt_d = lock_loss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slip_cnt_q      <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      slip_cnt_q      <= slip_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign o_slip_cnt      = slip_cnt_q;
  assign o_lock_loss_cnt = lock_loss_cnt_q;
`endif

endmodule

// File: doc/gt_rx_block_sync.md
Name: gt_rx_block_sync

Overview:
- Receive-side 64B/66B block synchronizer, clocked by the channel's o_rx_clk.
- Consumes the gearbox header/data stream from the GT channel wrapper and drives the wrapper's i_rx_slipbit until sync headers align.
- Asserts block lock and forwards lock-qualified blocks to the PCS descrambler/decoder.
- One instance per GT channel.

Parameters:
- SH_CNT_MAX, 64: headers per test window.
- SH_INVALID_MAX, 16: invalid headers within one window that cause loss of lock.
- SLIP_WAIT, 32: i_clk cycles after a slip pulse before header testing resumes; covers GTX gearbox slip settling.

Ports:
- i_clk  input  1  RX user clock (channel o_rx_clk).
- i_rst  input  1  reset, asynchronous, active-high.
- i_rx_data  input  64  gearbox payload.
- i_rx_valid  input  1  payload valid.
- i_rx_header  input  2  sync header.
- i_rx_header_valid  input  1  header valid; one per 66-bit block.
- o_rx_slipbit  output  1  one-cycle slip request to the GT channel.
- o_block_lock  output  1  block lock achieved.
- o_rx_data  output  64  registered payload.
- o_rx_header  output  2  registered header.
- o_rx_valid  output  1  payload valid, qualified by lock.

Behaviour:
- Reset values:
  - All outputs are 0.
  - State is LOCK_INIT.
  - sh_cnt = 0 and sh_invalid_cnt = 0.
- Valid header:
  - A header is valid when it is 2'b01 or 2'b10.
  - 2'b00 and 2'b11 are invalid.
  - Only cycles with i_rx_header_valid = 1 are evaluated.
- State LOCK_INIT:
  - Clears both counters and deasserts lock.
  - Goes to TEST_SH on the next cycle.
- State TEST_SH, on each header_valid cycle:
  - sh_cnt increments.
  - If the header is invalid, sh_invalid_cnt increments.
- TEST_SH while unlocked:
  - Any invalid header goes to SLIP.
  - When sh_cnt reaches SH_CNT_MAX with zero invalid headers, o_block_lock is set and both counters clear.
- TEST_SH while locked:
  - If sh_invalid_cnt reaches SH_INVALID_MAX, o_block_lock clears on the next cycle and the state goes to SLIP.
  - Otherwise, when sh_cnt reaches SH_CNT_MAX, both counters clear and lock is held.
- Simultaneous events: if the 64th header is also the 16th invalid header, loss of lock wins.
- State SLIP:
  - o_rx_slipbit = 1 for exactly one cycle.
  - Next state is SLIP_WAIT.
- State SLIP_WAIT:
  - Counts SLIP_WAIT cycles, ignoring all header_valid cycles.
  - Then clears both counters and returns to TEST_SH.
  - Lock stays 0 throughout.
- Consecutive slips are separated by at least SLIP_WAIT+1 cycles.
- Counter widths: sh_cnt is $clog2(SH_CNT_MAX+1) bits and sh_invalid_cnt is $clog2(SH_INVALID_MAX+1) bits. Neither counter wraps, because both clear at their thresholds.
- Data path:
  - Latency is 1 cycle.
  - o_rx_data and o_rx_header are registered from the inputs on every cycle.
  - o_rx_valid = registered (i_rx_valid & o_block_lock).
  - Blocks arriving while unlocked are dropped (o_rx_valid = 0).
- Reset mid-operation: returns immediately to the reset values. A slip pulse in progress is truncated.

Optional Feature:
- Macro: GT_RX_BLOCK_SYNC_STATS_EN.
- With the macro, two extra outputs are added, both cleared only by i_rst:
  - o_slip_cnt [15:0]: saturating count of slip pulses.
  - o_lock_loss_cnt [15:0]: saturating count of 1->0 transitions of o_block_lock.
- Without the macro, these ports and their counters do not exist.

Decomposition:
- Shared package gt_pcs_pkg holds:
  - the state enum (LOCK_INIT, TEST_SH, SLIP, SLIP_WAIT);
  - SYNC_HDR_DATA = 2'b01 and SYNC_HDR_CTRL = 2'b10;
  - the default values of SH_CNT_MAX, SH_INVALID_MAX and SLIP_WAIT.
- No sub-module; a single FSM plus counters.

Test Plan:
1. Steady 2'b01 headers from reset:
   - o_block_lock rises after the 64th header_valid, plus one cycle.
   - o_rx_valid follows one cycle after i_rx_valid.
   - o_rx_slipbit is never asserted.
2. Header 2'b11 on the 10th header while unlocked:
   - o_rx_slipbit pulses for one cycle.
   - No header is evaluated for the next 32 cycles.
   - Lock is then reached after 64 clean headers.
3. While locked, 15 invalid headers within a 64-header window:
   - Lock is held and counters clear at 64.
   - Repeating this for 3 windows keeps lock.
4. While locked, 16 invalid headers within a window:
   - o_block_lock drops and one slip pulse follows.
   - o_rx_valid goes to 0 from the next cycle.
5. Header generator with a misalignment of 7 bit positions:
   - Exactly 7 slip pulses, spaced at least 33 cycles apart, followed by lock.
   - With the macro defined, o_slip_cnt = 7.
6. Assert i_rst during SLIP_WAIT and during lock:
   - All outputs are 0 immediately.
   - Resync restarts from LOCK_INIT.
   - With the macro defined, o_lock_loss_cnt is unchanged by reset-induced drops (it reads 0 after reset).
